// File: rtl/image_feeder_pkg.sv
// Shared constants, FSM encoding and address type for the image feeder.
// Frame geometry defaults match the conv_layer_1 input image.
package image_feeder_pkg;

    localparam int IMG_WIDTH     = 28;
    localparam int IMG_HEIGHT    = 28;
    localparam int PIXEL_BITS    = 8;
    localparam int PIX_COUNT     = IMG_WIDTH * IMG_HEIGHT;
    localparam int PIX_ADDR_BITS = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } feed_state_t;

    typedef logic [PIX_ADDR_BITS-1:0] pix_addr_t;

    // Address constant for a pixel index, sized to the address bus.
    function automatic pix_addr_t pix_addr(input int idx);
        return pix_addr_t'(idx);
    endfunction

endpackage

// File: rtl/image_ram.sv
// Frame buffer: one write port, one registered read port, no reset,
// so synthesis can map it onto a block RAM.
module image_ram
    import image_feeder_pkg::*;
#(
    parameter int DEPTH     = PIX_COUNT,
    parameter int DATA_BITS = PIXEL_BITS
) (
    input  logic                 clk,
    input  logic                 we,
    input  pix_addr_t            wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 re,
    input  pix_addr_t            rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem [DEPTH];

    // Write port; the caller guarantees wr_addr < DEPTH when we is high.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port with a single cycle of latency.
    always_ff @(posedge clk) begin
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/image_feeder.sv
// Streams one stored frame, one pixel per cycle, into conv_layer_1.
// The host loads the frame buffer while the feeder is idle.
module image_feeder
    import image_feeder_pkg::*;
#(
    parameter int WIDTH     = IMG_WIDTH,
    parameter int HEIGHT    = IMG_HEIGHT,
    parameter int DATA_BITS = PIXEL_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [9:0]           wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 last_out,
    output logic                 done
);

    localparam int        FRAME     = WIDTH * HEIGHT;
    localparam pix_addr_t FRAME_END = pix_addr(FRAME);
    localparam pix_addr_t LAST_ADDR = pix_addr(FRAME - 1);

    feed_state_t          state;
    feed_state_t          state_nxt;
    pix_addr_t            rd_addr;
    logic                 rd_en;
    logic                 issue_last;
    logic                 wr_ok;
    logic                 valid_q;
    logic                 last_q;
    logic                 done_q;
    logic [DATA_BITS-1:0] ram_q;

    // busy also covers the done cycle, when the FSM is already back in IDLE.
    assign busy       = (state != IDLE) || done_q;
    assign rd_en      = (state == STREAM);
    assign issue_last = rd_en && (rd_addr == LAST_ADDR);
    assign wr_ok      = wr_en && !busy && (wr_addr < FRAME_END);

    assign valid_out = valid_q;
    assign last_out  = last_q;
    assign done      = done_q;
    assign data_out  = valid_q ? ram_q : '0;

    image_ram #(
        .DEPTH     (FRAME),
        .DATA_BITS (DATA_BITS)
    ) u_ram (
        .clk     (clk),
        .we      (wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .re      (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a start during the trailing done cycle is dropped.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start && !busy) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (issue_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Read-address counter: one address per STREAM cycle, cleared at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr <= '0;
        end else if (issue_last) begin
            rd_addr <= '0;
        end else if (rd_en) begin
            rd_addr <= rd_addr + pix_addr(1);
        end
    end

    // Output flags, aligned with the RAM read data one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= rd_en;
            last_q  <= issue_last;
            done_q  <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_image_feeder.sv
// Self-checking bench for image_feeder: vector table, corner sequences
// and randomized traffic against a cycle-indexed frame model.
module tb_image_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic [7:0] data_out;
    logic       valid_out;
    logic       last_out;
    logic       done;

    image_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .data_out  (data_out),
        .valid_out (valid_out),
        .last_out  (last_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    localparam int NPIX = 784;

    int checks = 0;
    int errors = 0;

    // Model: frame contents and the cycle at which the live frame was accepted.
    logic [7:0] model_mem [NPIX];
    int         t = 0;
    int         s = -1;

    logic       smp_busy;
    logic       smp_valid;
    logic       smp_last;
    logic       smp_done;
    logic [7:0] smp_data;

    typedef struct {
        int         cyc;
        logic       st;
        logic       we;
        logic [9:0] wa;
        logic [7:0] wd;
        logic       busy;
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic       done;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, t, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic tick(input logic r, input logic we, input logic [9:0] wa,
                        input logic [7:0] wd, input logic st);
        int         k;
        logic       eb;
        logic       ev;
        logic       el;
        logic       ed;
        logic [7:0] edat;
        rst     = r;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        start   = st;
        eb   = (s >= 0) && (t >= s + 1) && (t <= s + 786);
        k    = t - s - 2;
        ev   = (s >= 0) && (k >= 0) && (k < NPIX);
        el   = ev && (k == NPIX - 1);
        ed   = (s >= 0) && (t == s + 786);
        edat = ev ? model_mem[k] : 8'h00;
        @(negedge clk);
        smp_busy  = busy;
        smp_valid = valid_out;
        smp_last  = last_out;
        smp_done  = done;
        smp_data  = data_out;
        chk("busy", int'(smp_busy), int'(eb));
        chk("valid_out", int'(smp_valid), int'(ev));
        chk("last_out", int'(smp_last), int'(el));
        chk("done", int'(smp_done), int'(ed));
        chk("data_out", int'(smp_data), int'(edat));
        @(posedge clk);
        if (r) begin
            s = -1;
        end else begin
            if (we && (int'(wa) < NPIX) && !eb) model_mem[wa] = wd;
            if (st && !eb) s = t;
        end
        t++;
        #1;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    endtask

    initial begin
        int base;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        for (int i = 0; i < NPIX; i++) model_mem[i] = 8'h00;

        tbl[0]  = '{0,   1, 0, 10'd0, 8'h00, 0, 0, 8'd0,   0, 0};
        tbl[1]  = '{1,   0, 0, 10'd0, 8'h00, 1, 0, 8'd0,   0, 0};
        tbl[2]  = '{2,   0, 0, 10'd0, 8'h00, 1, 1, 8'd0,   0, 0};
        tbl[3]  = '{3,   0, 0, 10'd0, 8'h00, 1, 1, 8'd1,   0, 0};
        tbl[4]  = '{100, 0, 1, 10'd5, 8'hAA, 1, 1, 8'd98,  0, 0};
        tbl[5]  = '{257, 0, 0, 10'd0, 8'h00, 1, 1, 8'd255, 0, 0};
        tbl[6]  = '{258, 0, 0, 10'd0, 8'h00, 1, 1, 8'd0,   0, 0};
        tbl[7]  = '{300, 1, 0, 10'd0, 8'h00, 1, 1, 8'd42,  0, 0};
        tbl[8]  = '{784, 0, 0, 10'd0, 8'h00, 1, 1, 8'd14,  0, 0};
        tbl[9]  = '{785, 0, 0, 10'd0, 8'h00, 1, 1, 8'd15,  1, 0};
        tbl[10] = '{786, 1, 0, 10'd0, 8'h00, 1, 0, 8'd0,   0, 1};
        tbl[11] = '{787, 0, 0, 10'd0, 8'h00, 0, 0, 8'd0,   0, 0};
        tbl[12] = '{790, 0, 0, 10'd0, 8'h00, 0, 0, 8'd0,   0, 0};

        @(posedge clk);
        #1;
        tick(1'b1, 1'b0, 10'd0, 8'd0, 1'b0);
        tick(1'b1, 1'b0, 10'd0, 8'd0, 1'b0);

        for (int i = 0; i < NPIX; i++) tick(1'b0, 1'b1, 10'(i), 8'(i % 256), 1'b0);

        base = t;
        foreach (tbl[i]) begin
            while (t - base < tbl[i].cyc) idle();
            tick(1'b0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].st);
            chk($sformatf("tbl%0d.busy", i), int'(smp_busy), int'(tbl[i].busy));
            chk($sformatf("tbl%0d.valid", i), int'(smp_valid), int'(tbl[i].valid));
            chk($sformatf("tbl%0d.data", i), int'(smp_data), int'(tbl[i].data));
            chk($sformatf("tbl%0d.last", i), int'(smp_last), int'(tbl[i].last));
            chk($sformatf("tbl%0d.done", i), int'(smp_done), int'(tbl[i].done));
        end

        tick(1'b0, 1'b1, 10'd784, 8'h77, 1'b0);
        idle();

        base = t;
        tick(1'b0, 1'b0, 10'd0, 8'd0, 1'b1);
        while (t - base < 400) begin
            idle();
            if (t - base == 3) chk("f2.pix0", int'(smp_data), 0);
            if (t - base == 8) chk("f2.pix5_kept", int'(smp_data), 5);
        end
        tick(1'b1, 1'b0, 10'd0, 8'd0, 1'b0);
        idle();
        chk("abort.busy", int'(smp_busy), 0);
        chk("abort.valid", int'(smp_valid), 0);
        chk("abort.data", int'(smp_data), 0);
        for (int i = 0; i < 450; i++) begin
            idle();
            if (smp_done) chk("abort.no_done", 1, 0);
        end

        base = t;
        tick(1'b0, 1'b0, 10'd0, 8'd0, 1'b1);
        for (int i = 0; i < 790; i++) idle();

        tick(1'b0, 1'b1, 10'd0, 8'h3C, 1'b1);
        idle();
        idle();
        chk("same_cycle.pix0", int'(smp_data), 8'h3C);
        for (int i = 0; i < 790; i++) idle();

        for (int i = 0; i < 5000; i++) begin
            logic r;
            logic we;
            logic st;
            r  = ($urandom_range(0, 499) == 0);
            we = !r && ($urandom_range(0, 2) == 0);
            st = ($urandom_range(0, 59) == 0);
            tick(r, we, 10'($urandom_range(0, 1023)), 8'($urandom), st);
        end
        for (int i = 0; i < 800; i++) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
